// File: rtl/systolic_job_scheduler.sv
// Round-robin job scheduler for the 4-PE systolic array: streams one requester's
// weights, biases and activations into the array, then drains the four results.
module systolic_job_scheduler #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic [N_REQ-1:0] req_ready,
  output logic [7:0]       arr_data,
  output logic [3:0]       pe_weight_en,
  output logic [3:0]       pe_bias_en,
  output logic [3:0]       pe_acc_en,
  output logic [1:0]       drain_sel,
  input  logic [ACC_W-1:0] arr_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned N_PE      = 4;
  localparam int unsigned LAST_LOAD = 3;
  localparam int unsigned LAST_COMP = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_COMPUTE,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;

  logic               owner_valid;
  logic               streaming;
  logic               beat;

  // State, beat counter and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state and array control; enables only fire on an accepted beat
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    req_ready    = '0;
    pe_weight_en = '0;
    pe_bias_en   = '0;
    pe_acc_en    = '0;
    drain_sel    = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    res_id       = 1'b0;

    owner_valid = req_valid[owner_q];
    streaming   = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) ||
                  (state_q == S_COMPUTE);
    beat        = streaming && owner_valid;
    arr_data    = owner_q ? req_data1 : req_data0;
    busy        = (state_q != S_IDLE);

    if (streaming) begin
      req_ready[owner_q] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          // On a tie the requester not served last wins
          owner_d = (&req_valid) ? ~last_q : req_valid[1];
          state_d = S_LOAD_W;
          cnt_d   = '0;
        end
      end

      S_LOAD_W: begin
        if (beat) begin
          pe_weight_en[cnt_q[1:0]] = 1'b1;
          if (cnt_q == CNT_W'(LAST_LOAD)) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_LOAD_B: begin
        if (beat) begin
          pe_bias_en[cnt_q[1:0]] = 1'b1;
          if (cnt_q == CNT_W'(LAST_LOAD)) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_COMPUTE: begin
        if (beat) begin
          // PE i sees activations on beats i..i+3 as the wavefront passes
          for (int i = 0; i < int'(N_PE); i++) begin
            pe_acc_en[i] = (cnt_q >= CNT_W'(i)) && (cnt_q < CNT_W'(i + 4));
          end
          if (cnt_q == CNT_W'(LAST_COMP)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        drain_sel = cnt_q[1:0];
        res_valid = 1'b1;
        res_data  = arr_acc;
        res_id    = owner_q;
        if (res_ready) begin
          if (cnt_q == CNT_W'(LAST_LOAD)) begin
            last_d  = owner_q;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// Bench for systolic_job_scheduler: behavioural 4-PE array, table-driven single job,
// and a result scoreboard for arbitration, stall, backpressure and reset sequences.
module tb_systolic_job_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_data0;
  logic [7:0]  req_data1;
  logic [1:0]  req_ready;
  logic [7:0]  arr_data;
  logic [3:0]  pe_weight_en;
  logic [3:0]  pe_bias_en;
  logic [3:0]  pe_acc_en;
  logic [1:0]  drain_sel;
  logic [15:0] arr_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_id;
  logic        busy;

  systolic_job_scheduler #(.N_REQ(2), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .arr_data(arr_data), .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en),
    .pe_acc_en(pe_acc_en), .drain_sel(drain_sel), .arr_acc(arr_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: bias load seeds the accumulator, acc adds w*data
  logic [7:0]  w_m   [4];
  logic [15:0] acc_m [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pe_weight_en[i]) w_m[i] <= arr_data;
      if (pe_bias_en[i]) acc_m[i] <= 16'(arr_data);
      else if (pe_acc_en[i]) acc_m[i] <= acc_m[i] + 16'(w_m[i]) * 16'(arr_data);
    end
  end
  assign arr_acc = acc_m[drain_sel];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  data;
    logic        rr;
    logic [1:0]  ready;
    logic [3:0]  wen;
    logic [3:0]  ben;
    logic [3:0]  aen;
    logic [1:0]  dsel;
    logic        rv;
    logic        rid;
    logic [15:0] rdata;
    logic        busy;
  } vec_t;

  typedef struct {
    logic        id;
    logic [1:0]  sel;
    logic [15:0] data;
  } res_t;

  vec_t       tbl [21];
  res_t       exp_q [$];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [3:0] acc_log [$];
  int         beats0, beats1;
  int         gap_at0, gap_left0;
  bit         stall_arm;
  int         stall_left;
  logic [15:0] held;

  task automatic enqueue_job(input bit r);
    logic [7:0] w [4];
    logic [7:0] b [4];
    logic [7:0] d [7];
    res_t       e;
    logic [15:0] sum;
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom_range(1, 15));
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 7; i++) d[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) if (r) q1.push_back(w[i]); else q0.push_back(w[i]);
    for (int i = 0; i < 4; i++) if (r) q1.push_back(b[i]); else q0.push_back(b[i]);
    for (int i = 0; i < 7; i++) if (r) q1.push_back(d[i]); else q0.push_back(d[i]);
    for (int i = 0; i < 4; i++) begin
      sum = 16'(d[i]) + 16'(d[i+1]) + 16'(d[i+2]) + 16'(d[i+3]);
      e.id   = r;
      e.sel  = 2'(i);
      e.data = 16'(b[i]) + 16'(w[i]) * sum;
      exp_q.push_back(e);
    end
  endtask

  // One clock of queue-driven stimulus followed by mid-cycle checking
  task automatic step();
    bit   in_gap, in_stall;
    res_t e;
    @(posedge clk);
    #1;
    if (stall_arm && res_valid && drain_sel == 2'd1) begin
      stall_arm  = 1'b0;
      stall_left = 5;
      held       = res_data;
    end
    in_stall     = (stall_left > 0);
    res_ready    = !in_stall;
    in_gap       = (gap_left0 > 0) && (beats0 == gap_at0);
    req_valid[0] = (q0.size() > 0) && !in_gap;
    req_valid[1] = (q1.size() > 0);
    req_data0    = (q0.size() > 0) ? q0[0] : 8'h00;
    req_data1    = (q1.size() > 0) ? q1[0] : 8'h00;
    #3;
    if (req_ready == 2'b11) check("ready_both", 64'(req_ready), 64'h1);
    if (in_gap) begin
      check("gap_enables", 64'({pe_weight_en, pe_bias_en, pe_acc_en}), 64'h0);
      gap_left0--;
    end
    if (in_stall) begin
      check("stall_hold", 64'({res_valid, drain_sel, res_data}), 64'({1'b1, 2'd1, held}));
      stall_left--;
    end
    if (pe_acc_en != 4'h0) acc_log.push_back(pe_acc_en);
    if (req_valid[0] && req_ready[0]) begin void'(q0.pop_front()); beats0++; end
    if (req_valid[1] && req_ready[1]) begin void'(q1.pop_front()); beats1++; end
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'({res_id, drain_sel, res_data}), 64'h0_dead_beef);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({res_id, drain_sel, res_data}), 64'({e.id, e.sel, e.data}));
      end
    end
  endtask

  task automatic run_until_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !busy)
               && cycles < budget);
    if (cycles >= budget) check("timeout", 64'(cycles), 64'(budget + 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_table();
    logic [3:0] oh  [4];
    logic [3:0] acc [7];
    logic [15:0] rd [4];
    oh  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    acc = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rd  = '{16'd10, 16'd28, 16'd54, 16'd88};
    for (int r = 0; r < 21; r++) begin
      tbl[r] = '{valid: 2'b00, data: 8'h00, rr: 1'b0, ready: 2'b00, wen: 4'h0,
                 ben: 4'h0, aen: 4'h0, dsel: 2'd0, rv: 1'b0, rid: 1'b0,
                 rdata: 16'h0, busy: 1'b1};
    end
    tbl[0].valid  = 2'b01;
    tbl[0].busy   = 1'b0;
    tbl[20].busy  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tbl[1+k] = '{2'b01, 8'(k+1), 1'b0, 2'b01, oh[k], 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b1};
      tbl[5+k] = '{2'b01, 8'h00, 1'b0, 2'b01, 4'h0, oh[k], 4'h0, 2'd0, 1'b0, 1'b0, 16'h0, 1'b1};
      tbl[16+k] = '{2'b00, 8'h00, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 2'(k), 1'b1, 1'b0, rd[k], 1'b1};
    end
    for (int k = 0; k < 7; k++) begin
      tbl[9+k] = '{2'b01, 8'(k+1), 1'b0, 2'b01, 4'h0, 4'h0, acc[k], 2'd0, 1'b0, 1'b0, 16'h0, 1'b1};
    end
  endtask

  initial begin
    int         cyc;
    logic [27:0] got_seq;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data0 = 8'hA5;
    req_data1 = 8'h5A;
    res_ready = 1'b0;
    beats0 = 0; beats1 = 0; gap_at0 = 0; gap_left0 = 0;
    stall_arm = 1'b0; stall_left = 0; held = '0;
    fill_table();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs",
          64'({req_ready, pe_weight_en, pe_bias_en, pe_acc_en, drain_sel, res_valid, res_id, busy}),
          64'h0);
    check("reset_arr_data", 64'(arr_data), 64'h0A5);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Single job from requester 0, one row per cycle
    for (int r = 0; r < 21; r++) begin
      @(posedge clk);
      #1;
      req_valid = tbl[r].valid;
      req_data0 = tbl[r].data;
      req_data1 = 8'h00;
      res_ready = tbl[r].rr;
      #3;
      check($sformatf("table_row%0d", r),
            64'({req_ready, pe_weight_en, pe_bias_en, pe_acc_en, drain_sel, res_valid,
                 res_id, busy, (res_valid ? res_data : 16'h0)}),
            64'({tbl[r].ready, tbl[r].wen, tbl[r].ben, tbl[r].aen, tbl[r].dsel, tbl[r].rv,
                 tbl[r].rid, tbl[r].busy, tbl[r].rdata}));
    end

    // Both requesters valid from reset: 0 then 1, one IDLE between jobs
    do_reset();
    enqueue_job(1'b0);
    enqueue_job(1'b1);
    run_until_done(200, cyc);
    check("both_job_cycles", 64'(cyc), 64'd41);

    // Requester 0 stalls for 3 cycles at compute beat 2
    beats0 = 0; gap_at0 = 10; gap_left0 = 3;
    acc_log.delete();
    enqueue_job(1'b0);
    run_until_done(200, cyc);
    check("gap_job_cycles", 64'(cyc), 64'd24);
    got_seq = '0;
    for (int i = 0; i < acc_log.size() && i < 7; i++) got_seq[27-4*i -: 4] = acc_log[i];
    check("gap_acc_seq", 64'({acc_log.size() == 7, got_seq}), 64'({1'b1, 28'h137FEC8}));

    // Result backpressure at drain index 1
    stall_arm = 1'b1;
    enqueue_job(1'b1);
    run_until_done(200, cyc);
    check("stall_job_cycles", 64'(cyc), 64'd26);

    // Reset pulsed during LOAD_B drops the job
    beats0 = 0;
    enqueue_job(1'b0);
    cyc = 0;
    while (beats0 < 5 && cyc < 30) begin step(); cyc++; end
    check("reached_load_b", 64'(beats0), 64'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({req_ready, pe_weight_en, pe_bias_en, pe_acc_en, drain_sel, res_valid, res_id, busy}),
          64'h0);
    req_valid = 2'b00;
    q0.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enqueue_job(1'b1);
    run_until_done(200, cyc);
    check("post_reset_job_cycles", 64'(cyc), 64'd21);

    // Requester 1 alone, three back-to-back jobs
    for (int j = 0; j < 3; j++) enqueue_job(1'b1);
    run_until_done(300, cyc);
    check("r1_three_jobs_cycles", 64'(cyc), 64'd61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
